time_of_day_counter: RTL and testbench
======================================

# time_of_day_counter

Consumer end of the one-second tick produced by `sec_counter`. Each single-cycle `sec_tick` pulse advances a BCD hh:mm:ss time-of-day register with cascaded carries. The block also accepts a validated time-set load and raises a single-cycle alarm pulse when the running time reaches a programmed hh:mm. It sits between the seconds prescaler and the display/alarm logic of the clock.

## Interface

- `HOURS_PER_DAY`, default 24: hour wrap point. Hours count 00..HOURS_PER_DAY-1. Legal range 2..24.

Ports:

- `clk` in 1: system clock, 50 MHz.
- `reset_n` in 1: asynchronous, active-low reset.
- `sec_tick` in 1: one-cycle pulse from `sec_counter`, once per second. Consecutive-cycle pulses are legal and each one counts.
- `load` in 1: one-cycle request to overwrite the time with `load_time`.
- `load_time` in 24: BCD {hh[23:16], mm[15:8], ss[7:0]}.
- `alarm_time` in 16: BCD {hh[15:8], mm[7:0]}.
- `alarm_en` in 1: level; arms the alarm comparison.
- `time_out` out 24: current BCD time, {hh, mm, ss}, registered.
- `min_tick` out 1: one-cycle pulse when ss wraps 59->00.
- `hour_tick` out 1: one-cycle pulse when mm wraps 59->00.
- `day_tick` out 1: one-cycle pulse when hh wraps to 00.
- `alarm_hit` out 1: one-cycle alarm pulse.
- `load_err` out 1: one-cycle pulse when a load is rejected.

## Operation

- Reset (asynchronous assert, synchronous to `clk` on release): `time_out` = 24'h000000. All pulse outputs are 0.
- Tick: ss increments in BCD (ones 9->0 carries to tens). At ss==59, ss becomes 00, mm increments and `min_tick` fires. At mm==59 with the carry, mm becomes 00, hh increments and `hour_tick` fires. At hh==HOURS_PER_DAY-1 with the carry, hh becomes 00 and `day_tick` fires. 23:59:59 -> 00:00:00 fires all three pulses in the same cycle.
- Load validity: every nibble must be ≤9, ss ≤ 59, mm ≤ 59, hh ≤ HOURS_PER_DAY-1.
  - Valid load: time is replaced.
  - Invalid load: time is unchanged and `load_err` pulses.
- Load and tick in the same cycle: load wins. That tick is discarded, with no carry pulses, even if the load is invalid.
- Alarm: `alarm_hit` pulses only on a tick-driven update whose new value has hh:mm == `alarm_time`, ss == 00, and `alarm_en`=1.
  - A load landing on the alarm time does not fire.
  - An invalid or non-BCD `alarm_time` never matches.
  - The block has no snooze or latch; the alarm consumer holds state.
- Alarm-sequencing state: two states.
  - IDLE -> HIT when the alarm condition holds.
  - HIT -> IDLE on the next cycle unconditionally.
  - `alarm_hit` = (state==HIT).

## Timing

- Tick latency: a `sec_tick` sampled at edge N updates `time_out` at edge N. The new value is visible in cycle N+1.
- `min_tick`, `hour_tick` and `day_tick` are registered at the same edge as the time update, so they are coincident with the new `time_out`.
- `alarm_hit` is asserted in the cycle after the matching `time_out` first appears, i.e. one cycle later.
- Load latency: the new `time_out`, or `load_err`, appears one cycle after `load` is sampled.
- Reset asserted mid-cycle clears time and pulses immediately. A pulse truncated by reset is not regenerated.
- No handshake back-pressure: every accepted tick is processed in the cycle it arrives.

## Structure

- Package `alarm_clock_pkg`:
  - typedef `bcd_time_t`, a packed struct of hh/mm/ss 8-bit BCD fields.
  - typedef `bcd_hm_t`.
  - constants `SEC_MAX=8'h59` and `MIN_MAX=8'h59`.
  - function `bcd_valid`.
- Sub-module `bcd_mod_counter`: parameterised modulus, with `inc` and `load` inputs and `value` and `wrap` outputs. It is instantiated three times (ss, mm, hh) with the wrap chaining to the next stage's `inc`.
- Top level holds load validation, priority muxing, pulse registers and the alarm FSM.

## Test plan

- Reset, then 60 ticks spaced 3 cycles apart -> `time_out`=24'h000100, `min_tick` exactly once, coincident with 24'h000100.
- Load 24'h235958, then 2 ticks -> 24'h235959, then 24'h000000 with `min_tick`, `hour_tick` and `day_tick` all high in one cycle.
- Load 24'h0A1000 (bad nibble), and separately 24'h126000 (mm=60) -> `time_out` unchanged, `load_err` one cycle each.
- `load`=1 and `sec_tick`=1 together with `load_time`=24'h101010 -> `time_out`=24'h101010 next cycle, no carry pulses. Then ticks on two consecutive cycles -> 24'h101012.
- `alarm_time`=16'h0700, `alarm_en`=1, load 24'h065959, tick -> 24'h070000 and `alarm_hit` one cycle later for one cycle. Repeat with `alarm_en`=0 -> no hit. Load 24'h070000 directly -> no hit.
- `HOURS_PER_DAY`=12: load 24'h115959, tick -> 24'h000000 with `day_tick`. Assert `reset_n`=0 mid-run -> outputs zero asynchronously.

Source files
------------

// File: rtl/alarm_clock_pkg.sv
// Shared BCD time types and helpers for the alarm clock datapath.
package alarm_clock_pkg;

    typedef struct packed {
        logic [7:0] hh;
        logic [7:0] mm;
        logic [7:0] ss;
    } bcd_time_t;

    typedef struct packed {
        logic [7:0] hh;
        logic [7:0] mm;
    } bcd_hm_t;

    localparam logic [7:0] SEC_MAX = 8'h59;
    localparam logic [7:0] MIN_MAX = 8'h59;

    function automatic logic bcd_valid(input logic [7:0] v);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
    endfunction

    // Two-digit BCD encoding of a small non-negative integer.
    function automatic logic [7:0] to_bcd8(input int n);
        return 8'((((n / 10) % 10) * 16) + (n % 10));
    endfunction

endpackage

// File: rtl/time_of_day_counter_if.sv
// Tick/load/alarm signal bundle between the seconds prescaler, the clock core and the display logic.
interface time_of_day_counter_if;
    logic        sec_tick;
    logic        load;
    logic [23:0] load_time;
    logic [15:0] alarm_time;
    logic        alarm_en;
    logic [23:0] time_out;
    logic        min_tick;
    logic        hour_tick;
    logic        day_tick;
    logic        alarm_hit;
    logic        load_err;

    modport master (
        output sec_tick, load, load_time, alarm_time, alarm_en,
        input  time_out, min_tick, hour_tick, day_tick, alarm_hit, load_err
    );

    modport slave (
        input  sec_tick, load, load_time, alarm_time, alarm_en,
        output time_out, min_tick, hour_tick, day_tick, alarm_hit, load_err
    );
endinterface

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter wrapping at MODULUS-1; wrap is the combinational carry into the next stage.
module bcd_mod_counter
    import alarm_clock_pkg::*;
#(
    parameter int MODULUS = 60
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       inc,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic [7:0] value,
    output logic       wrap
);

    localparam logic [7:0] MAX_BCD = to_bcd8(MODULUS - 1);

    assign wrap = inc && !load && (value == MAX_BCD);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            value <= 8'h00;
        end else if (load) begin
            value <= load_val;
        end else if (inc) begin
            if (value == MAX_BCD)
                value <= 8'h00;
            else if (value[3:0] == 4'd9)
                value <= {value[7:4] + 4'd1, 4'h0};
            else
                value <= {value[7:4], value[3:0] + 4'd1};
        end
    end

endmodule

// File: rtl/time_of_day_counter.sv
// BCD hh:mm:ss time-of-day register with validated load, carry pulses and a one-shot alarm.
module time_of_day_counter
    import alarm_clock_pkg::*;
#(
    parameter int HOURS_PER_DAY = 24
) (
    input logic                  clk,
    input logic                  reset_n,
    time_of_day_counter_if.slave bus
);

    localparam logic [7:0] HH_MAX = to_bcd8(HOURS_PER_DAY - 1);
    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] HIT    = 1'b1;

    bcd_time_t  ld_time;
    bcd_hm_t    alarm_hm;
    logic       load_ok;
    logic       alarm_ok;
    logic       tick_p0;
    logic       ss_wrap, mm_wrap, hh_wrap;
    logic [7:0] ss_val, mm_val, hh_val;
    logic       tick_vld_p1;
    logic       min_tick_p1, hour_tick_p1, day_tick_p1, load_err_p1;
    logic       alarm_match;
    logic [0:0] alarm_state;

    assign ld_time  = bcd_time_t'(bus.load_time);
    assign alarm_hm = bcd_hm_t'(bus.alarm_time);

    assign load_ok = bus.load
                  && bcd_valid(ld_time.hh) && bcd_valid(ld_time.mm) && bcd_valid(ld_time.ss)
                  && (ld_time.ss <= SEC_MAX) && (ld_time.mm <= MIN_MAX) && (ld_time.hh <= HH_MAX);

    // A load request, valid or not, swallows a coincident tick.
    assign tick_p0 = bus.sec_tick && !bus.load;

    bcd_mod_counter #(.MODULUS(60)) u_ss (
        .clk(clk), .reset_n(reset_n), .inc(tick_p0), .load(load_ok),
        .load_val(ld_time.ss), .value(ss_val), .wrap(ss_wrap)
    );

    bcd_mod_counter #(.MODULUS(60)) u_mm (
        .clk(clk), .reset_n(reset_n), .inc(ss_wrap), .load(load_ok),
        .load_val(ld_time.mm), .value(mm_val), .wrap(mm_wrap)
    );

    bcd_mod_counter #(.MODULUS(HOURS_PER_DAY)) u_hh (
        .clk(clk), .reset_n(reset_n), .inc(mm_wrap), .load(load_ok),
        .load_val(ld_time.hh), .value(hh_val), .wrap(hh_wrap)
    );

    // Stage p0 -> p1: pulses registered at the same edge as the time update.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_vld_p1  <= 1'b0;
            min_tick_p1  <= 1'b0;
            hour_tick_p1 <= 1'b0;
            day_tick_p1  <= 1'b0;
            load_err_p1  <= 1'b0;
        end else begin
            tick_vld_p1  <= tick_p0;
            min_tick_p1  <= ss_wrap;
            hour_tick_p1 <= mm_wrap;
            day_tick_p1  <= hh_wrap;
            load_err_p1  <= bus.load && !load_ok;
        end
    end

    assign alarm_ok = bcd_valid(alarm_hm.hh) && bcd_valid(alarm_hm.mm)
                   && (alarm_hm.mm <= MIN_MAX) && (alarm_hm.hh <= HH_MAX);

    // Only a tick-driven update qualifies, so a load onto the alarm time stays silent.
    assign alarm_match = tick_vld_p1 && bus.alarm_en && alarm_ok
                      && (ss_val == 8'h00)
                      && (hh_val == alarm_hm.hh) && (mm_val == alarm_hm.mm);

    // Stage p1 -> p2: alarm sequencing.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            alarm_state <= IDLE;
        end else begin
            case (alarm_state)
                IDLE:    alarm_state <= alarm_match ? HIT : IDLE;
                default: alarm_state <= IDLE;
            endcase
        end
    end

    assign bus.time_out  = {hh_val, mm_val, ss_val};
    assign bus.min_tick  = min_tick_p1;
    assign bus.hour_tick = hour_tick_p1;
    assign bus.day_tick  = day_tick_p1;
    assign bus.load_err  = load_err_p1;
    assign bus.alarm_hit = (alarm_state == HIT);

endmodule

// File: tb/tb_time_of_day_counter.sv
// Bench for time_of_day_counter: vector table, multi-cycle sequences and random stimulus vs a seconds-of-day model.
module tb_time_of_day_counter;

    logic clk = 1'b0;
    logic rst_n;
    logic rst12_n;

    always #5 clk = ~clk;

    time_of_day_counter_if ifc24();
    time_of_day_counter_if ifc12();

    time_of_day_counter #(.HOURS_PER_DAY(24)) dut24 (
        .clk(clk), .reset_n(rst_n), .bus(ifc24)
    );

    time_of_day_counter #(.HOURS_PER_DAY(12)) dut12 (
        .clk(clk), .reset_n(rst12_n), .bus(ifc12)
    );

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic        tick;
        logic        ld;
        logic [23:0] lt;
        logic [15:0] at;
        logic        en;
        logic [23:0] exp_t;
        logic [4:0]  exp_p;   // {min, hour, day, alarm, load_err}
    } vec_t;

    vec_t tbl[$];

    // Reference model: time kept as seconds since midnight.
    int   m_secs;
    bit   m_tick_upd;
    logic m_min, m_hour, m_day, m_alarm, m_err;

    function automatic logic [7:0] bcd2(input int n);
        return 8'(((n / 10) * 16) + (n % 10));
    endfunction

    function automatic logic [23:0] secs_to_bcd(input int s);
        return {bcd2(s / 3600), bcd2((s / 60) % 60), bcd2(s % 60)};
    endfunction

    function automatic bit digits_ok(input logic [7:0] b);
        return (b[7:4] < 10) && (b[3:0] < 10);
    endfunction

    function automatic int num2(input logic [7:0] b);
        return int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    task automatic model_step(input logic t, input logic l, input logic [23:0] lt,
                              input logic [15:0] at, input logic en);
        bit lv, av;
        int ls, am;
        lv = digits_ok(lt[23:16]) && digits_ok(lt[15:8]) && digits_ok(lt[7:0])
          && num2(lt[23:16]) < 24 && num2(lt[15:8]) < 60 && num2(lt[7:0]) < 60;
        ls = num2(lt[23:16]) * 3600 + num2(lt[15:8]) * 60 + num2(lt[7:0]);
        av = digits_ok(at[15:8]) && digits_ok(at[7:0])
          && num2(at[15:8]) < 24 && num2(at[7:0]) < 60;
        am = num2(at[15:8]) * 60 + num2(at[7:0]);
        m_alarm = m_tick_upd && en && av && (m_secs % 60 == 0) && (m_secs / 60 == am);
        m_min = 0; m_hour = 0; m_day = 0; m_err = 0; m_tick_upd = 0;
        if (l) begin
            if (lv) m_secs = ls;
            else    m_err = 1;
        end else if (t) begin
            m_secs     = (m_secs + 1) % 86400;
            m_min      = (m_secs % 60 == 0);
            m_hour     = (m_secs % 3600 == 0);
            m_day      = (m_secs == 0);
            m_tick_upd = 1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [4:0] pulses24();
        return {ifc24.min_tick, ifc24.hour_tick, ifc24.day_tick, ifc24.alarm_hit, ifc24.load_err};
    endfunction

    function automatic logic [4:0] pulses12();
        return {ifc12.min_tick, ifc12.hour_tick, ifc12.day_tick, ifc12.alarm_hit, ifc12.load_err};
    endfunction

    task automatic cycle(input logic t, input logic l, input logic [23:0] lt,
                         input logic [15:0] at, input logic en, input bit chk);
        ifc24.sec_tick   = t;
        ifc24.load       = l;
        ifc24.load_time  = lt;
        ifc24.alarm_time = at;
        ifc24.alarm_en   = en;
        @(posedge clk);
        model_step(t, l, lt, at, en);
        #1;
        if (chk) begin
            check("model_time", 32'(ifc24.time_out), 32'(secs_to_bcd(m_secs)));
            check("model_pulses", 32'(pulses24()), 32'({m_min, m_hour, m_day, m_alarm, m_err}));
        end
    endtask

    task automatic cyc12(input logic t, input logic l, input logic [23:0] lt);
        ifc12.sec_tick  = t;
        ifc12.load      = l;
        ifc12.load_time = lt;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int          min_cnt;
        logic [23:0] min_time;
        int          r_am;
        logic [15:0] r_at;
        logic        r_en;
        logic        t, l;
        logic [23:0] lt;
        int          s;

        rst_n = 1'b0;
        rst12_n = 1'b0;
        ifc24.sec_tick = 0; ifc24.load = 0; ifc24.load_time = 0; ifc24.alarm_time = 0; ifc24.alarm_en = 0;
        ifc12.sec_tick = 0; ifc12.load = 0; ifc12.load_time = 0; ifc12.alarm_time = 0; ifc12.alarm_en = 0;
        m_secs = 0; m_tick_upd = 0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_time", 32'(ifc24.time_out), 32'h000000);
        check("reset_pulses", 32'(pulses24()), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // 60 spaced ticks roll exactly one minute.
        min_cnt = 0;
        min_time = 24'hFFFFFF;
        for (int i = 0; i < 60; i++) begin
            for (int k = 0; k < 3; k++) begin
                cycle(k == 0, 1'b0, 24'h0, 16'h0000, 1'b0, 1'b1);
                if (ifc24.min_tick) begin
                    min_cnt++;
                    min_time = ifc24.time_out;
                end
            end
        end
        check("min_tick_count", 32'(min_cnt), 32'd1);
        check("min_tick_time", 32'(min_time), 32'h000100);
        check("minute_time", 32'(ifc24.time_out), 32'h000100);

        tbl.push_back(vec_t'{1'b0, 1'b1, 24'h235958, 16'h0000, 1'b0, 24'h235958, 5'b00000});
        tbl.push_back(vec_t'{1'b1, 1'b0, 24'h000000, 16'h0000, 1'b0, 24'h235959, 5'b00000});
        tbl.push_back(vec_t'{1'b1, 1'b0, 24'h000000, 16'h0000, 1'b0, 24'h000000, 5'b11100});
        tbl.push_back(vec_t'{1'b0, 1'b0, 24'h000000, 16'h0000, 1'b0, 24'h000000, 5'b00000});
        tbl.push_back(vec_t'{1'b0, 1'b1, 24'h0A1000, 16'h0000, 1'b0, 24'h000000, 5'b00001});
        tbl.push_back(vec_t'{1'b0, 1'b0, 24'h000000, 16'h0000, 1'b0, 24'h000000, 5'b00000});
        tbl.push_back(vec_t'{1'b0, 1'b1, 24'h126000, 16'h0000, 1'b0, 24'h000000, 5'b00001});
        tbl.push_back(vec_t'{1'b1, 1'b1, 24'h101010, 16'h0000, 1'b0, 24'h101010, 5'b00000});
        tbl.push_back(vec_t'{1'b1, 1'b0, 24'h000000, 16'h0000, 1'b0, 24'h101011, 5'b00000});
        tbl.push_back(vec_t'{1'b1, 1'b0, 24'h000000, 16'h0000, 1'b0, 24'h101012, 5'b00000});
        tbl.push_back(vec_t'{1'b0, 1'b1, 24'h065959, 16'h0700, 1'b1, 24'h065959, 5'b00000});
        tbl.push_back(vec_t'{1'b1, 1'b0, 24'h000000, 16'h0700, 1'b1, 24'h070000, 5'b11000});
        tbl.push_back(vec_t'{1'b0, 1'b0, 24'h000000, 16'h0700, 1'b1, 24'h070000, 5'b00010});
        tbl.push_back(vec_t'{1'b0, 1'b0, 24'h000000, 16'h0700, 1'b1, 24'h070000, 5'b00000});
        tbl.push_back(vec_t'{1'b0, 1'b1, 24'h065959, 16'h0700, 1'b0, 24'h065959, 5'b00000});
        tbl.push_back(vec_t'{1'b1, 1'b0, 24'h000000, 16'h0700, 1'b0, 24'h070000, 5'b11000});
        tbl.push_back(vec_t'{1'b0, 1'b0, 24'h000000, 16'h0700, 1'b0, 24'h070000, 5'b00000});
        tbl.push_back(vec_t'{1'b0, 1'b1, 24'h070000, 16'h0700, 1'b1, 24'h070000, 5'b00000});
        tbl.push_back(vec_t'{1'b0, 1'b0, 24'h000000, 16'h0700, 1'b1, 24'h070000, 5'b00000});
        tbl.push_back(vec_t'{1'b1, 1'b1, 24'h999999, 16'h0000, 1'b0, 24'h070000, 5'b00001});
        tbl.push_back(vec_t'{1'b0, 1'b1, 24'h240000, 16'h0000, 1'b0, 24'h070000, 5'b00001});
        tbl.push_back(vec_t'{1'b1, 1'b0, 24'h000000, 16'h0000, 1'b0, 24'h070001, 5'b00000});

        foreach (tbl[i]) begin
            cycle(tbl[i].tick, tbl[i].ld, tbl[i].lt, tbl[i].at, tbl[i].en, 1'b0);
            check($sformatf("vec%0d_time", i), 32'(ifc24.time_out), 32'(tbl[i].exp_t));
            check($sformatf("vec%0d_pulses", i), 32'(pulses24()), 32'(tbl[i].exp_p));
        end

        // Random traffic, with loads steered just short of the alarm minute.
        r_am = 420; r_at = 16'h0700; r_en = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            if (i % 400 == 0) begin
                r_am = $urandom_range(0, 1439);
                r_at = {bcd2(r_am / 60), bcd2(r_am % 60)};
                r_en = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 7) == 0) r_at = 16'h07A0;
            end
            t = ($urandom_range(0, 2) != 0);
            l = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 3) == 0) begin
                lt = 24'($urandom);
            end else begin
                if ($urandom_range(0, 1) == 1) s = r_am * 60 - int'($urandom_range(1, 4));
                else                           s = int'($urandom_range(0, 86399));
                if (s < 0) s += 86400;
                lt = secs_to_bcd(s);
            end
            cycle(t, l, lt, r_at, r_en, 1'b1);
        end
        cycle(1'b0, 1'b0, 24'h0, 16'h0, 1'b0, 1'b1);

        // 12-hour instance: wrap, hour range and asynchronous reset.
        @(negedge clk);
        rst12_n = 1'b1;
        cyc12(1'b0, 1'b1, 24'h115959);
        check("h12_load", 32'(ifc12.time_out), 32'h115959);
        cyc12(1'b1, 1'b0, 24'h0);
        check("h12_wrap_time", 32'(ifc12.time_out), 32'h000000);
        check("h12_wrap_pulses", 32'(pulses12()), 32'b11100);
        cyc12(1'b0, 1'b1, 24'h120000);
        check("h12_bad_hour_time", 32'(ifc12.time_out), 32'h000000);
        check("h12_bad_hour_err", 32'(pulses12()), 32'b00001);
        cyc12(1'b0, 1'b1, 24'h115959);
        cyc12(1'b1, 1'b0, 24'h0);
        check("h12_pre_reset_day", 32'(ifc12.day_tick), 32'h1);
        #3;
        rst12_n = 1'b0;
        #1;
        check("h12_async_time", 32'(ifc12.time_out), 32'h000000);
        check("h12_async_pulses", 32'(pulses12()), 32'h0);
        cyc12(1'b1, 1'b0, 24'h0);
        check("h12_held_time", 32'(ifc12.time_out), 32'h000000);
        @(negedge clk);
        rst12_n = 1'b1;
        cyc12(1'b1, 1'b0, 24'h0);
        check("h12_after_reset", 32'(ifc12.time_out), 32'h000001);
        cyc12(1'b0, 1'b0, 24'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
